// File: rtl/hamming_decoder_if.sv
// rtl/hamming_decoder_if.sv - byte stream handshake bundle for the SECDED decoder
interface hamming_decoder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  // Producer/consumer side (memory reader and writer, or a testbench)
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Decoder side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - byte-serial SECDED Hamming(16,11) decoder with error counters
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  hamming_decoder_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] dbl_count
);

  typedef enum logic [2:0] {
    RX_LO  = 3'd0,
    RX_HI  = 3'd1,
    DECODE = 3'd2,
    TX_LO  = 3'd3,
    TX_HI  = 3'd4
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_CORR = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  state_t state;
  state_t state_next;

  // Received code word: bit 0 is overall parity, bit i is Hamming position i
  logic [15:0] word;
  // Registered decode result presented during the two TX states
  logic [10:0] data;
  logic [1:0]  flags;

  // Combinational decode of the current word (only consumed in DECODE)
  logic [3:0]  syndrome;
  logic        parity;
  logic [15:0] fixed;
  logic [10:0] data_next;
  logic [1:0]  flags_next;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Syndrome / overall parity classification and single-bit correction
  always_comb begin
    syndrome   = '0;
    parity     = ^word;
    fixed      = word;
    flags_next = FLAG_NONE;
    for (int i = 1; i < 16; i++) begin
      if (word[i]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
    if (parity) begin
      // Odd overall parity means exactly one flipped bit; syndrome 0 points at p0,
      // whose flip leaves the data positions untouched.
      flags_next = FLAG_CORR;
      if (syndrome != 4'd0) begin
        fixed[syndrome] = ~word[syndrome];
      end
    end else if (syndrome != 4'd0) begin
      // Even parity with a non-zero syndrome: two flips, not correctable
      flags_next = FLAG_DBL;
    end
    data_next = {fixed[15:9], fixed[7:5], fixed[3]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/output decode
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    busy          = 1'b1;
    case (state)
      RX_LO: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          state_next = RX_HI;
        end
      end
      RX_HI: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = TX_LO;
      end
      TX_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = data[7:0];
        if (bus.out_ready) begin
          state_next = TX_HI;
        end
      end
      TX_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {flags, 3'b000, data[10:8]};
        if (bus.out_ready) begin
          state_next = RX_LO;
        end
      end
      default: begin
        state_next = RX_LO;
      end
    endcase
  end

  // Byte capture into the word register and result registration in DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      data  <= '0;
      flags <= FLAG_NONE;
    end else begin
      if (state == RX_LO && bus.in_valid) begin
        word[7:0] <= bus.in_data;
      end
      if (state == RX_HI && bus.in_valid) begin
        word[15:8] <= bus.in_data;
      end
      if (state == DECODE) begin
        data  <= data_next;
        flags <= flags_next;
      end
    end
  end

  // Saturating event counters, bumped once per decoded word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count <= '0;
      dbl_count  <= '0;
    end else if (state == DECODE) begin
      if (flags_next == FLAG_CORR && corr_count != CNT_MAX) begin
        corr_count <= corr_count + 1'b1;
      end
      if (flags_next == FLAG_DBL && dbl_count != CNT_MAX) begin
        dbl_count <= dbl_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// tb/tb_hamming_decoder.sv - randomized self-checking bench for hamming_decoder
module tb_hamming_decoder;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] corr_count;
  logic [7:0] dbl_count;
  logic       busy2;
  logic [1:0] corr_count2;
  logic [1:0] dbl_count2;

  hamming_decoder_if bus ();
  hamming_decoder_if bus2 ();

  // Narrow-counter copy sees exactly the same stimulus as the main instance
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  hamming_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .corr_count (corr_count),
    .dbl_count  (dbl_count)
  );

  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .busy       (busy2),
    .corr_count (corr_count2),
    .dbl_count  (dbl_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int corr_n = 0;
  int dbl_n = 0;

  int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic        par;
    int          p;
    w = '0;
    for (int k = 0; k < 11; k++) w[dpos[k]] = d[k];
    for (int b = 0; b < 4; b++) begin
      p = 1 << b;
      par = 1'b0;
      for (int i = 1; i < 16; i++) if ((i & p) != 0 && i != p) par = par ^ w[i];
      w[p] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    for (int k = 0; k < 11; k++) d[k] = w[dpos[k]];
    return d;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // All tasks start and end just after a falling edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("out_valid_timeout", 32'd0, 32'd1);
    b = bus.out_data;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_corr"}, corr_count, sat(corr_n, 255));
    check({tag, "_dbl"}, dbl_count, sat(dbl_n, 255));
    check({tag, "_corr2"}, corr_count2, sat(corr_n, 3));
    check({tag, "_dbl2"}, dbl_count2, sat(dbl_n, 3));
  endtask

  task automatic run_word(input string tag, input logic [15:0] w, input logic [7:0] elo,
                          input logic [7:0] ehi, input int hold);
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] first;
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    check({tag, "_decode"}, {bus.in_ready, bus.out_valid, busy}, 3'b001);
    @(negedge clk);
    check({tag, "_latency"}, bus.out_valid, 1'b1);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      first = bus.out_data;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        check({tag, "_hold_data"}, bus.out_data, first);
        check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
        check({tag, "_hold_inrdy"}, bus.in_ready, 1'b0);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
    end
    recv_byte(lo);
    recv_byte(hi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
    if (ehi[7:6] == 2'b01) corr_n++;
    if (ehi[7:6] == 2'b10) dbl_n++;
    check_counters(tag);
    check({tag, "_idle"}, {busy, bus.in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [10:0] d;
    logic [15:0] w;
    logic [10:0] ed;
    logic [1:0]  ef;
    int          nerr;
    int          p1;
    int          p2;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check_counters("rst");
    rst = 1'b0;
    @(negedge clk);

    run_word("clean", 16'h000F, 8'h01, 8'h00, 0);
    run_word("single", 16'h002F, 8'h01, 8'h40, 0);
    run_word("p0err", 16'h000E, 8'h01, 8'h40, 0);
    run_word("double", 16'h022F, 8'h13, 8'h80, 0);
    run_word("ones", 16'hFFFF, 8'hFF, 8'h07, 0);
    run_word("backpressure", 16'h000F, 8'h01, 8'h00, 10);

    // Reset with only the low byte captured; the next byte must be a fresh low byte
    send_byte(8'h5A);
    check("rxhi_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_rxhi_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    corr_n = 0;
    dbl_n = 0;
    @(negedge clk);
    run_word("after_rst", 16'h000F, 8'h01, 8'h00, 0);

    // Asynchronous reset while presenting output drops out_valid before any edge
    send_byte(8'h2F);
    send_byte(8'h00);
    @(negedge clk);
    check("tx_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    corr_n = 0;
    dbl_n = 0;
    @(negedge clk);
    check_counters("rst_tx");

    // Narrow counter saturates at 3 while the wide one keeps counting
    for (int k = 0; k < 4; k++) run_word("sat", 16'h002F, 8'h01, 8'h40, 0);
    check("sat_corr2", corr_count2, 2'd3);
    check("sat_corr", corr_count, 8'd4);

    // Random data with 0, 1 or 2 injected bit flips
    for (int t = 0; t < 150; t++) begin
      d = 11'($urandom_range(0, 2047));
      w = encode(d);
      nerr = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) w[p1] = ~w[p1];
      if (nerr == 2) w[p2] = ~w[p2];
      ed = (nerr == 2) ? extract(w) : d;
      ef = (nerr == 0) ? 2'b00 : (nerr == 1) ? 2'b01 : 2'b10;
      run_word("rand", w, ed[7:0], {ef, 3'b000, ed[10:8]},
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
Byte-serial SECDED Hamming (16,11) decoder. It is the hardware inverse of the encode flow the CPU runs in software with its parity, XOR and shift-or ALU ops. The block accepts an encoded 16-bit word as two bytes over a valid/ready stream and returns the 11 data bits plus a 2-bit error status as two bytes. It sits beside the datapath as a memory-side accelerator: the data-memory reader feeds it, and the writer drains it.

Parameters:
CNT_W, 8, width of the saturating single-corrected and double-detected event counters

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
InValid  input  1  InData holds a valid encoded byte
InData  input  8  encoded byte; low byte (w[7:0]) first, then high byte (w[15:8])
InReady  output  1  block accepts InData this cycle
OutValid  output  1  OutData holds a valid decoded byte
OutData  output  8  decoded byte; low byte first, then high byte
OutReady  input  1  consumer accepts OutData this cycle
Busy  output  1  high in any state except RX_LO
CorrCount  output  CNT_W  number of single-error words (corrected), saturating
DblCount  output  CNT_W  number of double-error words (detected), saturating

Behaviour:
- Clocking: one clock, Clk. Reset is asynchronous and active-high.
- Reset values:
  - State = RX_LO; internal word and result registers = 0.
  - InReady = 1, OutValid = 0, OutData = 0, Busy = 0, CorrCount = 0, DblCount = 0.
- Word layout: w[0] = overall parity p0; w[i] = Hamming position i for i = 1..15.
  - Parity positions: 1, 2, 4, 8.
  - Data d1..d11 = w3, w5, w6, w7, w9, w10, w11, w12, w13, w14, w15.
- States:
  - RX_LO: InReady = 1. On InValid, latch w[7:0] and go to RX_HI.
  - RX_HI: InReady = 1. On InValid, latch w[15:8] and go to DECODE.
  - DECODE: one cycle, InReady = 0. Compute and register the result, then go to TX_LO.
  - TX_LO: OutValid = 1, OutData = {d8..d1}. On OutReady, go to TX_HI.
  - TX_HI: OutValid = 1, OutData = {F1, F0, 3'b000, d11, d10, d9}. On OutReady, go to RX_LO.
- A byte transfers only when valid and ready are both high in the same cycle. InReady = 0 in DECODE/TX_LO/TX_HI, so there is no overlap of input and output words.
- Latency: the last input handshake is in cycle N. DECODE runs in cycle N+1. OutValid first goes high in cycle N+2.
- Decode:
  - Syndrome s[3:0] = XOR of the indices i (1..15) for which w[i] = 1.
  - Overall parity P = ^w[15:0].
  - s = 0, P = 0: no error; F = 2'b00.
  - P = 1: single error; F = 2'b01.
    - If s != 0, flip w[s] before extracting data.
    - If s = 0, the error is in p0 and the data is unchanged.
    - CorrCount increments.
  - s != 0, P = 0: double error; F = 2'b10. Data is extracted uncorrected. DblCount increments.
  - F = 2'b11 is never produced.
- Counters: update in the DECODE cycle and saturate at all-ones, with no wrap. They clear only on Reset.
- Output hold rules:
  - OutData and OutValid stay stable while OutValid = 1 and OutReady = 0.
  - InValid asserted while InReady = 0 is ignored; the upstream must hold the byte.
- Reset mid-operation (any state): the partial word is discarded and the next accepted byte is treated as a low byte. OutValid drops immediately because reset is asynchronous.
- Back-to-back: with OutReady tied high, one word completes every 5 cycles (2 RX + 1 DECODE + 2 TX).

Test Plan:
- Clean word: in 0x0F, 0x00 (d1 = 1) -> out 0x01, 0x00; counters unchanged.
- Single error, data bit: in 0x2F, 0x00 (bit 5 flipped) -> out 0x01, 0x40; CorrCount = 1.
- Single error in p0: in 0x0E, 0x00 -> out 0x01, 0x40; CorrCount increments.
- Double error: in 0x2F, 0x02 (bits 5 and 9 flipped) -> out 0x13, 0x80; DblCount = 1.
- All-ones word: in 0xFF, 0xFF -> out 0xFF, 0x07.
- Backpressure plus reset:
  - Hold OutReady = 0 for 10 cycles in TX_LO -> OutData stays stable and InReady = 0 throughout.
  - Assert Reset in RX_HI -> next bytes 0x0F, 0x00 decode as a fresh word (0x01, 0x00).
  - With CNT_W = 2, four single-error words leave CorrCount = 3.
